// File: rtl/pc_trace_tx.sv
// pc_trace_tx: observes committed PC values, queues them in a small FIFO and
// streams each one to a host as an 8N1 UART frame (sync byte + PC, MSB first).
// Purely passive: the processor is never stalled or altered.
module pc_trace_tx #(
  parameter int         PC_WIDTH     = 32,
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [PC_WIDTH-1:0]           PC,
  input  logic                          PC_VALID,
  input  logic                          ENABLE,
  input  logic                          CLR_OVF,
  output logic                          TX,
  output logic                          BUSY,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NB = PC_WIDTH / 8;
  localparam int IW = $clog2(NB + 1);

  localparam logic [BW-1:0] BAUD_LAST      = BW'(CLKS_PER_BIT - 1);
  // The last stop bit of a frame is one cycle short; the IDLE cycle that
  // follows (TX still high) completes it, so frames stay gap-free.
  localparam logic [BW-1:0] BAUD_STOP_LAST = BW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] NB_I           = IW'(NB);
  localparam logic [LW-1:0] DEPTH_L        = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t                state_r, state_nxt;
  logic [BW-1:0]         baud_r, baud_nxt;
  logic [2:0]            bit_r, bit_nxt;
  logic [IW-1:0]         byte_r, byte_nxt;
  logic [7:0]            shift_r, shift_nxt;
  logic [PC_WIDTH-1:0]   word_r, word_nxt;
  logic                  tx_s, tx_r, busy_r, ovf_r, ovf_nxt;
  logic [LW-1:0]         level_r, level_nxt;
  logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [PC_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic                  push_s, pop_s, full_s, push_ok_s, drop_s;

  // FIFO bookkeeping: accepted pushes, drops, occupancy and sticky overflow.
  always_comb begin
    push_s    = PC_VALID && ENABLE;
    full_s    = (level_r == DEPTH_L);
    push_ok_s = push_s && (!full_s || pop_s);
    drop_s    = push_s && full_s && !pop_s;
    level_nxt = level_r;
    if (push_ok_s && !pop_s) begin
      level_nxt = level_r + 1'b1;
    end else if (!push_ok_s && pop_s) begin
      level_nxt = level_r - 1'b1;
    end else begin
      level_nxt = level_r;
    end
    if (drop_s) begin
      ovf_nxt = 1'b1;
    end else if (CLR_OVF) begin
      ovf_nxt = 1'b0;
    end else begin
      ovf_nxt = ovf_r;
    end
  end

  // UART framer next-state: bit timing, byte sequencing and line level.
  always_comb begin
    state_nxt = state_r;
    baud_nxt  = baud_r;
    bit_nxt   = bit_r;
    byte_nxt  = byte_r;
    shift_nxt = shift_r;
    word_nxt  = word_r;
    pop_s     = 1'b0;
    tx_s      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        tx_s = 1'b1;
        if (level_r != {LW{1'b0}}) begin
          pop_s     = 1'b1;
          word_nxt  = mem_r[rd_ptr_r];
          shift_nxt = SYNC_BYTE;
          byte_nxt  = {IW{1'b0}};
          baud_nxt  = {BW{1'b0}};
          state_nxt = ST_START;
        end else begin
          baud_nxt  = {BW{1'b0}};
        end
      end
      ST_START: begin
        tx_s = 1'b0;
        if (baud_r == BAUD_LAST) begin
          baud_nxt  = {BW{1'b0}};
          bit_nxt   = 3'd0;
          state_nxt = ST_DATA;
        end else begin
          baud_nxt  = baud_r + 1'b1;
        end
      end
      ST_DATA: begin
        tx_s = shift_r[0];
        if (baud_r == BAUD_LAST) begin
          baud_nxt  = {BW{1'b0}};
          shift_nxt = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            state_nxt = ST_STOP;
          end else begin
            bit_nxt   = bit_r + 1'b1;
          end
        end else begin
          baud_nxt  = baud_r + 1'b1;
        end
      end
      ST_STOP: begin
        tx_s = 1'b1;
        if (byte_r != NB_I) begin
          if (baud_r == BAUD_LAST) begin
            baud_nxt  = {BW{1'b0}};
            shift_nxt = word_r[PC_WIDTH-1 -: 8];
            word_nxt  = word_r << 4'd8;
            byte_nxt  = byte_r + 1'b1;
            state_nxt = ST_START;
          end else begin
            baud_nxt  = baud_r + 1'b1;
          end
        end else begin
          if (baud_r == BAUD_STOP_LAST) begin
            baud_nxt  = {BW{1'b0}};
            state_nxt = ST_IDLE;
          end else begin
            baud_nxt  = baud_r + 1'b1;
          end
        end
      end
      default: begin
        tx_s      = 1'b1;
        baud_nxt  = {BW{1'b0}};
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset drives the line idle at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= ST_IDLE;
      baud_r   <= {BW{1'b0}};
      bit_r    <= 3'd0;
      byte_r   <= {IW{1'b0}};
      shift_r  <= 8'd0;
      word_r   <= {PC_WIDTH{1'b0}};
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      ovf_r    <= 1'b0;
      level_r  <= {LW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      state_r  <= state_nxt;
      baud_r   <= baud_nxt;
      bit_r    <= bit_nxt;
      byte_r   <= byte_nxt;
      shift_r  <= shift_nxt;
      word_r   <= word_nxt;
      tx_r     <= tx_s;
      busy_r   <= (state_nxt != ST_IDLE) || (level_nxt != {LW{1'b0}});
      ovf_r    <= ovf_nxt;
      level_r  <= level_nxt;
      wr_ptr_r <= push_ok_s ? wr_ptr_r + 1'b1 : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + 1'b1 : rd_ptr_r;
    end
  end

  // FIFO storage; contents are only meaningful below LEVEL so need no reset.
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= PC;
    end
  end

  assign TX       = tx_r;
  assign BUSY     = busy_r;
  assign OVERFLOW = ovf_r;
  assign LEVEL    = level_r;

endmodule

// File: tb/tb_pc_trace_tx.sv
// Directed bench for pc_trace_tx with a UART byte monitor on TX.
module tb_pc_trace_tx;
  localparam int W = 32;
  localparam int C = 4;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] PC = '0;
  logic         PC_VALID = 1'b0;
  logic         ENABLE = 1'b1;
  logic         CLR_OVF = 1'b0;
  logic         TX, BUSY, OVERFLOW;
  logic [2:0]   LEVEL;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int frm_err = 0;
  logic [7:0] rx_q[$];
  int         st_q[$];
  logic [7:0] exp_q[$];
  int rx_base = 0;
  int err_base = 0;

  pc_trace_tx #(.PC_WIDTH(W), .CLKS_PER_BIT(C), .FIFO_DEPTH(D), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .RST(RST), .PC(PC), .PC_VALID(PC_VALID), .ENABLE(ENABLE),
    .CLR_OVF(CLR_OVF), .TX(TX), .BUSY(BUSY), .OVERFLOW(OVERFLOW), .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // UART monitor: detects start edge, samples mid-bit, logs bytes and start cycles.
  initial begin
    logic       prev;
    logic [7:0] b;
    int         st;
    prev = 1'b1;
    forever begin
      @(negedge CLK);
      if (prev && (TX === 1'b0)) begin
        st = cyc;
        repeat (C / 2) @(negedge CLK);
        if (TX !== 1'b0) frm_err = frm_err + 1;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge CLK);
          b[i] = TX;
        end
        repeat (C) @(negedge CLK);
        if (TX !== 1'b1) frm_err = frm_err + 1;
        rx_q.push_back(b);
        st_q.push_back(st);
        prev = 1'b1;
      end else begin
        prev = TX;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expf(input logic [31:0] pc);
    exp_q.push_back(8'hA5);
    exp_q.push_back(pc[31:24]);
    exp_q.push_back(pc[23:16]);
    exp_q.push_back(pc[15:8]);
    exp_q.push_back(pc[7:0]);
  endtask

  task automatic mark();
    rx_base  = rx_q.size();
    err_base = frm_err;
    exp_q.delete();
  endtask

  task automatic check_rx(input string tag);
    int n;
    int bad;
    logic [31:0] got;
    n = rx_q.size() - rx_base;
    chk({tag, "_nbytes"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < n) ? 32'(rx_q[rx_base + i]) : 32'hFFFF_FFFF;
      chk($sformatf("%s_byte%0d", tag, i), got, 32'(exp_q[i]));
    end
    bad = 0;
    for (int i = rx_base + 1; i < rx_q.size(); i++) begin
      if (st_q[i] - st_q[i-1] != 10 * C) bad++;
    end
    chk({tag, "_gaps"}, 32'(bad), 32'd0);
    chk({tag, "_framing"}, 32'(frm_err - err_base), 32'd0);
  endtask

  initial begin
    int cnt;
    int lvl_max;
    logic [2:0] exp_lvl [8];
    logic       exp_ovf [8];

    // ---- reset ----
    step(3);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    RST = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (TX !== 1'b1 || BUSY !== 1'b0) cnt++;
    end
    chk("idle_1000", 32'(cnt), 32'd0);

    // ---- single frame ----
    mark();
    expf(32'h0040_0010);
    PC = 32'h0040_0010; PC_VALID = 1'b1;
    step(1);                       // edge k
    PC_VALID = 1'b0;
    chk("sf_level_k", 32'(LEVEL), 32'd1);
    chk("sf_busy_k", 32'(BUSY), 32'd1);
    step(1);                       // k+1 : pop
    chk("sf_level_k1", 32'(LEVEL), 32'd0);
    chk("sf_tx_k1", 32'(TX), 32'd1);
    step(1);                       // k+2 : start bit
    chk("sf_tx_k2", 32'(TX), 32'd0);
    step(197);                     // k+199
    chk("sf_busy_k199", 32'(BUSY), 32'd1);
    step(1);                       // k+200
    chk("sf_busy_k200", 32'(BUSY), 32'd0);
    step(5);
    check_rx("sf");

    // ---- back-to-back ----
    mark();
    expf(32'h0); expf(32'h4); expf(32'h8);
    lvl_max = 0;
    PC = 32'h0; PC_VALID = 1'b1;
    step(1);
    chk("bb_level_k", 32'(LEVEL), 32'd1);
    PC = 32'h4;
    step(1);
    chk("bb_level_k1", 32'(LEVEL), 32'd1);
    PC = 32'h8;
    step(1);
    PC_VALID = 1'b0;
    chk("bb_level_k2", 32'(LEVEL), 32'd2);
    for (int i = 0; i < 600; i++) begin
      if (int'(LEVEL) > lvl_max) lvl_max = int'(LEVEL);
      step(1);
    end
    chk("bb_level_peak", 32'(lvl_max), 32'd2);
    chk("bb_busy_end", 32'(BUSY), 32'd0);
    step(5);
    check_rx("bb");

    // ---- overflow ----
    mark();
    exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      PC = 32'h0000_1000 + 32'(4 * i); PC_VALID = 1'b1;
      if (i < 5) expf(32'h0000_1000 + 32'(4 * i));
      step(1);                     // edge k+i
      chk($sformatf("ov_level_%0d", i), 32'(LEVEL), 32'(exp_lvl[i]));
      chk($sformatf("ov_flag_%0d", i), 32'(OVERFLOW), 32'(exp_ovf[i]));
    end
    PC = 32'hDEAD_0000; CLR_OVF = 1'b1;       // drop and clear together
    step(1);                                  // k+8
    chk("ov_drop_wins", 32'(OVERFLOW), 32'd1);
    chk("ov_level_k8", 32'(LEVEL), 32'd4);
    PC_VALID = 1'b0;
    step(1);                                  // k+9
    CLR_OVF = 1'b0;
    chk("ov_cleared", 32'(OVERFLOW), 32'd0);
    step(191);                                // k+200 : IDLE cycle, FIFO full
    chk("ov_full_idle", 32'(LEVEL), 32'd4);
    PC = 32'hDEAD_BEEF; PC_VALID = 1'b1;      // push while full with pop
    expf(32'hDEAD_BEEF);
    step(1);                                  // k+201
    PC_VALID = 1'b0;
    chk("ov_pushpop_level", 32'(LEVEL), 32'd4);
    chk("ov_pushpop_flag", 32'(OVERFLOW), 32'd0);
    step(1005);
    chk("ov_busy_end", 32'(BUSY), 32'd0);
    chk("ov_level_end", 32'(LEVEL), 32'd0);
    check_rx("ov");

    // ---- ENABLE gating ----
    mark();
    ENABLE = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      PC = 32'h5555_0000 + 32'(i); PC_VALID = 1'b1;
      step(1);
      PC_VALID = 1'b0;
      if (LEVEL !== 3'd0) cnt++;
      step(1);
    end
    for (int i = 0; i < 50; i++) begin
      if (TX !== 1'b1 || LEVEL !== 3'd0) cnt++;
      step(1);
    end
    chk("en_gated", 32'(cnt), 32'd0);
    ENABLE = 1'b1;
    expf(32'h1234_5678);
    PC = 32'h1234_5678; PC_VALID = 1'b1;
    step(1);
    PC_VALID = 1'b0;
    step(30);
    ENABLE = 1'b0;                            // dropped mid-frame
    step(180);
    chk("en_busy_end", 32'(BUSY), 32'd0);
    check_rx("en");
    ENABLE = 1'b1;

    // ---- reset mid-frame ----
    PC = 32'hC5FE_F00D; PC_VALID = 1'b1;
    step(1);                                  // k
    PC = 32'h7777_0000;
    step(1);                                  // k+1
    PC_VALID = 1'b0;
    step(58);                                 // k+59 : byte 1, data bit 3 (0)
    chk("mr_tx_before", 32'(TX), 32'd0);
    chk("mr_level_before", 32'(LEVEL), 32'd1);
    RST = 1'b0;
    #1;
    chk("mr_tx_async", 32'(TX), 32'd1);
    chk("mr_level_async", 32'(LEVEL), 32'd0);
    chk("mr_busy_async", 32'(BUSY), 32'd0);
    step(2);
    RST = 1'b1;
    step(50);
    mark();
    expf(32'h0000_ABCD);
    PC = 32'h0000_ABCD; PC_VALID = 1'b1;
    step(1);
    PC_VALID = 1'b0;
    step(205);
    chk("mr_busy_end", 32'(BUSY), 32'd0);
    check_rx("mr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
